imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage of the RV32I pipeline.
- Accepts one instruction word plus its PC per cycle over a valid/ready handshake.
- Decodes every RV32I immediate format (I, S, B, U, J, shift-amount), sign-extends to WIDTH and computes the PC-relative target.
- Result is registered behind a 2-entry skid buffer, so the execute stage can stall without losing instructions.

Parameters:
- WIDTH, 32, datapath/XLEN width of imm, pc and target; must be >= 32.
- RESET_PC, 0, value loaded into the out_pc and out_target registers on reset.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline flush (branch mispredict/redirect).
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  block can accept an instruction this cycle.
- in_instr  input  32  instruction word.
- in_pc  input  WIDTH  PC of in_instr.
- out_valid  output  1  registered result valid.
- out_ready  input  1  downstream accepts the result.
- out_imm  output  WIDTH  extended immediate.
- out_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- out_pc  output  WIDTH  PC carried with the result.
- out_target  output  WIDTH  out_pc + out_imm, modulo 2^WIDTH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid = 0, skid valid = 0.
  - out_imm = 0, out_fmt = 0, out_pc = RESET_PC, out_target = RESET_PC.
  - in_ready = 1 throughout reset.
  - Reset mid-transfer discards both entries.
- Decode is combinational on in_instr[6:0]:
  - 0000011 load, 1100111 jalr, 0010011 op-imm: I-type, imm = sext(instr[31:20]).
  - 0010011 with funct3 = 001 or 101: SHAMT, imm = zero-extended instr[24:20]. funct7 is not part of imm.
  - 0100011: S, imm = sext({instr[31:25], instr[11:7]}).
  - 1100011: B, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111 / 0010111: U, imm = sext({instr[31:12], 12'b0}). Sign-extended from bit 31 when WIDTH > 32.
  - 1101111: J, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Any other opcode: NONE, imm = 0.
- out_target = pc + imm, computed before the register, wraps modulo 2^WIDTH. Computed for every format; the consumer decides whether to use it.
- Latency: 1 cycle, from accept (in_valid & in_ready) to out_valid.
- in_ready = !skid_valid, driven directly from a register (no combinational path from out_ready).
- Output stage loads when it is empty or out_ready = 1:
  - Source is the skid entry if valid, otherwise the newly accepted input.
- Accept while the output stage holds and out_ready = 0: data goes to the skid entry. in_ready drops the next cycle.
- Accept in the same cycle the skid drains to the output: the new data goes to the skid entry, preserving order.
- Stability: while out_valid = 1 and out_ready = 0, all out_* are held stable.
- Flush (sync):
  - Next cycle out_valid = 0 and skid valid = 0.
  - Any input accepted in the flush cycle is discarded.
  - in_ready = 1 the cycle after.
  - Flush has priority over every transfer.
- Simultaneous out_ready = 1 and full skid: the skid moves to the output and in_ready rises the next cycle.

Optional Feature:
- Macro IMM_GEN_ILLEGAL_EN.
- Defined:
  - Adds output port out_illegal (1 bit), registered alongside out_imm, reset 0.
  - out_illegal is set when the format is NONE and the opcode is not 0110011 (OP), 0001111 (FENCE) or 1110011 (SYSTEM).
  - out_illegal is set for any instruction with in_instr[1:0] != 11.
- Undefined: port absent; unknown opcodes silently produce NONE with imm 0.

Test Plan:
1. Load and LUI decode: accept 0xFFC12083 (lw x1,-4(x2)) -> 1 cycle later out_imm = 0xFFFFFFFC, out_fmt = 1. Accept 0x12345037 (lui) -> out_imm = 0x12345000, out_fmt = 4.
2. Branch target: beq 0xFE000CE3 with in_pc = 0x00000100 -> out_imm = 0xFFFFFFF8, out_fmt = 3, out_target = 0x000000F8. Same instruction with in_pc = 0x4 -> out_target = 0xFFFFFFFC (wrap).
3. Shift amount: srai 0x4030D093 -> out_imm = 0x00000003 (not 0x403), out_fmt = 6. add 0x002081B3 -> out_imm = 0, out_fmt = 0.
4. Backpressure: out_ready = 0, push A then B on consecutive cycles -> in_ready = 0 the cycle after B, out_* hold A. Raise out_ready -> A then B emerge in order, in_ready returns to 1, no loss or duplication.
5. Flush: both entries full, assert flush with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, and the flushed-cycle input never appears.
6. Async reset: pull rst_n low mid-stall with both entries full -> out_valid = 0 immediately (before the clock edge), out_pc = RESET_PC. After release, first accepted instruction appears after exactly 1 cycle.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RV32I immediate generator with PC-relative target, registered behind a 2-entry skid buffer.
// Optional IMM_GEN_ILLEGAL_EN adds out_illegal for unknown or non-32-bit encodings.
module imm_gen_pipe #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [WIDTH-1:0] in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_imm,
   output logic [2:0]       out_fmt,
   output logic [WIDTH-1:0] out_pc,
   output logic [WIDTH-1:0] out_target
`ifdef IMM_GEN_ILLEGAL_EN
   ,
   output logic             out_illegal
`endif
);

   localparam logic [2:0] FMT_NONE  = 3'd0;
   localparam logic [2:0] FMT_I     = 3'd1;
   localparam logic [2:0] FMT_S     = 3'd2;
   localparam logic [2:0] FMT_B     = 3'd3;
   localparam logic [2:0] FMT_U     = 3'd4;
   localparam logic [2:0] FMT_J     = 3'd5;
   localparam logic [2:0] FMT_SHAMT = 3'd6;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
`ifdef IMM_GEN_ILLEGAL_EN
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
`endif

   typedef struct packed {
      logic [WIDTH-1:0] imm;
      logic [2:0]       fmt;
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] target;
`ifdef IMM_GEN_ILLEGAL_EN
      logic             illegal;
`endif
   } res_t;

   logic [6:0]  opc;
   logic [2:0]  funct3;
   logic        is_i;
   logic        is_s;
   logic        is_b;
   logic        is_u;
   logic        is_j;
   logic        is_shamt;
   logic [31:0] imm32;
   logic [2:0]  fmt;
   res_t        dec;
   res_t        out_q;
   res_t        skid_q;
   logic        skid_valid;
   logic        accept;
   logic        load_out;

   assign opc    = in_instr[6:0];
   assign funct3 = in_instr[14:12];

   assign is_shamt = (opc == OPC_OPIMM) &&
                     ((funct3 == 3'b001) || (funct3 == 3'b101));
   assign is_i = (opc == OPC_LOAD) || (opc == OPC_JALR) ||
                 ((opc == OPC_OPIMM) && !is_shamt);
   assign is_s = (opc == OPC_STORE);
   assign is_b = (opc == OPC_BRANCH);
   assign is_u = (opc == OPC_LUI) || (opc == OPC_AUIPC);
   assign is_j = (opc == OPC_JAL);

   always_comb begin
      imm32 = '0;
      fmt   = FMT_NONE;
      unique case (1'b1)
         is_shamt: begin
            imm32 = {27'b0, in_instr[24:20]};
            fmt   = FMT_SHAMT;
         end
         is_i: begin
            imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            fmt   = FMT_I;
         end
         is_s: begin
            imm32 = {{20{in_instr[31]}},
                     in_instr[31:25], in_instr[11:7]};
            fmt   = FMT_S;
         end
         is_b: begin
            imm32 = {{20{in_instr[31]}}, in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
            fmt   = FMT_B;
         end
         is_u: begin
            imm32 = {in_instr[31:12], 12'b0};
            fmt   = FMT_U;
         end
         is_j: begin
            imm32 = {{12{in_instr[31]}}, in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
            fmt   = FMT_J;
         end
         default: ;
      endcase
   end

   // Every 32-bit immediate is already sign-correct, so one widening cast suffices.
   always_comb begin
      dec        = '0;
      dec.imm    = WIDTH'($signed(imm32));
      dec.fmt    = fmt;
      dec.pc     = in_pc;
      dec.target = in_pc + dec.imm;
`ifdef IMM_GEN_ILLEGAL_EN
      dec.illegal = (in_instr[1:0] != 2'b11) ||
                    ((fmt == FMT_NONE) &&
                     (opc != OPC_OP) &&
                     (opc != OPC_FENCE) &&
                     (opc != OPC_SYSTEM));
`endif
   end

   assign in_ready = !skid_valid;
   assign accept   = in_valid && in_ready;
   assign load_out = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         skid_valid   <= 1'b0;
         out_q        <= '0;
         out_q.pc     <= RESET_PC;
         out_q.target <= RESET_PC;
         skid_q       <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (load_out) begin
         if (skid_valid) begin
            // Skid is older than anything arriving now; new data queues behind it.
            out_q      <= skid_q;
            out_valid  <= 1'b1;
            skid_valid <= accept;
            if (accept) skid_q <= dec;
         end else begin
            out_valid <= accept;
            if (accept) out_q <= dec;
         end
      end else if (accept) begin
         skid_q     <= dec;
         skid_valid <= 1'b1;
      end
   end

   assign out_imm    = out_q.imm;
   assign out_fmt    = out_q.fmt;
   assign out_pc     = out_q.pc;
   assign out_target = out_q.target;
`ifdef IMM_GEN_ILLEGAL_EN
   assign out_illegal = out_q.illegal;
`endif

endmodule
